// File: rtl/ysyx_22051145_muldiv_unit_if.sv
// ysyx_22051145_muldiv_unit_if: request/result handshake bundle between the
// execute stage (master) and the iterative multiply/divide unit (slave).
interface ysyx_22051145_muldiv_unit_if #(
   parameter int XLEN = 64
);
   logic            valid_i;
   logic            ready_o;
   logic [7:0]      op_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic [4:0]      rd_i;
   logic            result_valid_o;
   logic            result_ready_i;
   logic [XLEN-1:0] result_o;
   logic [4:0]      rd_o;

   modport master (
      output valid_i, op_i, rs1_i, rs2_i, rd_i, result_ready_i,
      input  ready_o, result_valid_o, result_o, rd_o
   );

   modport slave (
      input  valid_i, op_i, rs1_i, rs2_i, rd_i, result_ready_i,
      output ready_o, result_valid_o, result_o, rd_o
   );
endinterface

// File: rtl/ysyx_22051145_muldiv_unit.sv
// ysyx_22051145_muldiv_unit: iterative RV64M multiply/divide unit.
// A shift-add multiplier (LSB first) and a restoring divider (MSB first)
// share one 2*XLEN accumulator and retire one bit per CALC cycle.
// Optional feature macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow divides register their fixed result at the accept edge and skip CALC.
module ysyx_22051145_muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush_i,
   output logic                      busy_o,
   ysyx_22051145_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int OP_MUL    = 0;
   localparam int OP_MULH   = 1;
   localparam int OP_MULHSU = 2;
   localparam int OP_MULHU  = 3;
   localparam int OP_DIV    = 4;
   localparam int OP_DIVU   = 5;
   localparam int OP_REM    = 6;
   localparam int OP_REMU   = 7;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   // RISC-V fixed results: x/0 gives all ones (quotient) or x (remainder);
   // INT_MIN/-1 gives INT_MIN (quotient) or 0 (remainder).
   function automatic logic [XLEN-1:0] special_val(input logic is_quot, input logic div0,
                                                   input logic [XLEN-1:0] dividend);
      if (div0) return is_quot ? '1 : dividend;
      return is_quot ? dividend : '0;
   endfunction

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [7:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              sign_q, sign_d;
   logic              div0_q, div0_d;
   logic              ovf_q, ovf_d;
   logic [XLEN-1:0]   a_q, a_d;      // multiplicand magnitude, or raw rs1 for divides
   logic [XLEN-1:0]   b_q, b_d;      // divisor magnitude
   logic [2*XLEN-1:0] acc_q, acc_d;  // {product hi | remainder, product lo | multiplier | quotient}

   // Request decode
   logic            in_one_hot, accept, in_div, s1, s2, in_sign, in_div0, in_ovf;
   logic [XLEN-1:0] mag1, mag2;

   assign in_one_hot = (bus.op_i != 8'd0) && ((bus.op_i & (bus.op_i - 8'd1)) == 8'd0);
   assign accept     = bus.valid_i && (state_q == S_IDLE) && in_one_hot && !flush_i;
   assign in_div     = |bus.op_i[OP_REMU:OP_DIV];
   assign s1         = (bus.op_i[OP_MULH] | bus.op_i[OP_MULHSU] | bus.op_i[OP_DIV] | bus.op_i[OP_REM])
                       & bus.rs1_i[XLEN-1];
   assign s2         = (bus.op_i[OP_MULH] | bus.op_i[OP_DIV] | bus.op_i[OP_REM]) & bus.rs2_i[XLEN-1];
   assign in_sign    = bus.op_i[OP_REM] ? s1 : (s1 ^ s2);
   assign mag1       = s1 ? ('0 - bus.rs1_i) : bus.rs1_i;
   assign mag2       = s2 ? ('0 - bus.rs2_i) : bus.rs2_i;
   assign in_div0    = in_div && (bus.rs2_i == '0);
   assign in_ovf     = (bus.op_i[OP_DIV] | bus.op_i[OP_REM]) && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);

   // One iteration step of the shared datapath
   logic [XLEN-1:0]   acc_hi, acc_lo, div_rem, div_mag, div_fix, final_res;
   logic [XLEN:0]     mul_sum, div_shift;
   logic              is_div_q, div_ge;
   logic [2*XLEN-1:0] acc_step, prod_fix;

   assign acc_hi    = acc_q[2*XLEN-1:XLEN];
   assign acc_lo    = acc_q[XLEN-1:0];
   assign is_div_q  = |op_q[OP_REMU:OP_DIV];
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
   assign div_shift = {acc_hi, acc_lo[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   assign div_rem   = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
   assign acc_step  = is_div_q ? {div_rem, acc_lo[XLEN-2:0], div_ge} : {mul_sum, acc_lo[XLEN-1:1]};
   assign prod_fix  = sign_q ? ('0 - acc_step) : acc_step;
   assign div_mag   = (op_q[OP_DIV] | op_q[OP_DIVU]) ? acc_step[XLEN-1:0] : acc_step[2*XLEN-1:XLEN];
   assign div_fix   = sign_q ? ('0 - div_mag) : div_mag;

   // Final-cycle result select, with the fixed special-case values on top
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves final_res unassigned (latch).
      final_res = div_fix;
      if (op_q[OP_MUL]) begin
         final_res = prod_fix[XLEN-1:0];
      end else if (op_q[OP_MULH] | op_q[OP_MULHSU] | op_q[OP_MULHU]) begin
         final_res = prod_fix[2*XLEN-1:XLEN];
      end
      if (div0_q | ovf_q) final_res = special_val(op_q[OP_DIV] | op_q[OP_DIVU], div0_q, a_q);
   end

   // Sequencer next state: IDLE accepts, CALC iterates, DONE holds until taken
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      rd_d     = rd_q;
      result_d = result_q;
      sign_d   = sign_q;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = bus.op_i;
               rd_d    = bus.rd_i;
               sign_d  = in_sign;
               div0_d  = in_div0;
               ovf_d   = in_ovf;
               a_d     = in_div ? bus.rs1_i : mag1;
               b_d     = mag2;
               acc_d   = {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
               cnt_d   = '0;
               state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
               if (in_div0 || in_ovf) begin
                  result_d = special_val(bus.op_i[OP_DIV] | bus.op_i[OP_DIVU], in_div0, bus.rs1_i);
                  state_d  = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
               result_d = final_res;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.result_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   // State registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         result_q <= '0;
         sign_q   <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of order.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         sign_q   <= sign_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
      end
   end

   assign bus.ready_o        = (state_q == S_IDLE);
   assign bus.result_valid_o = (state_q == S_DONE);
   assign bus.result_o       = result_q;
   assign bus.rd_o           = rd_q;
   assign busy_o             = (state_q != S_IDLE);
endmodule

// File: tb/tb_ysyx_22051145_muldiv_unit.sv
// tb_ysyx_22051145_muldiv_unit: directed vectors with hand-computed results.
// The driver pushes the expected result on acceptance; a separate monitor pops
// and compares whenever a result is handed over.
module tb_ysyx_22051145_muldiv_unit;
   localparam int XLEN = 64;
   localparam int LAT  = XLEN + 1;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_SP = 1;
`else
   localparam int LAT_SP = XLEN + 1;
`endif
   localparam logic [7:0] OP_MUL = 8'h01, OP_MULH = 8'h02, OP_MULHSU = 8'h04, OP_MULHU = 8'h08;
   localparam logic [7:0] OP_DIV = 8'h10, OP_DIVU = 8'h20, OP_REM = 8'h40, OP_REMU = 8'h80;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
   localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;

   typedef struct {
      string       name;
      logic [63:0] res;
      logic [4:0]  rd;
      int          lat;
      int          acc_cyc;
   } exp_t;

   typedef struct {
      string       name;
      logic [7:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush_i;
   logic busy_o;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   first_valid = -1;
   exp_t sb[$];
   vec_t vq[$];

   ysyx_22051145_muldiv_unit_if #(.XLEN(XLEN)) bus ();

   ysyx_22051145_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush_i(flush_i),
      .busy_o (busy_o),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
   endtask

   function automatic void add(input string name, input logic [7:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] res, input int lat);
      vq.push_back('{name: name, op: op, a: a, b: b, res: res, lat: lat});
   endfunction

   task automatic drive(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd);
      bus.valid_i = 1'b1;
      bus.op_i    = op;
      bus.rs1_i   = a;
      bus.rs2_i   = b;
      bus.rd_i    = rd;
   endtask

   // Returns at posedge+1 after the accept edge; e is the cycle count at that point.
   task automatic wait_accept(input string name, output int e);
      bit got, now;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         now = bus.ready_o && !flush_i;
         @(posedge clk);
         #1;
         got = now;
      end
      bus.valid_i = 1'b0;
      e = cyc;
      check({name, " accepted"}, got, 1);
   endtask

   task automatic do_op(input string name, input logic [7:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] res,
                        input int lat, output int e);
      drive(op, a, b, rd);
      wait_accept(name, e);
      sb.push_back('{name: name, res: res, rd: rd, lat: lat, acc_cyc: e});
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("scoreboard drained", sb.size(), 0);
   endtask

   // Monitor: compare every handed-over result against the scoreboard head
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n || !bus.result_valid_o) begin
         first_valid = -1;
      end else begin
         if (first_valid < 0) first_valid = cyc;
         if (bus.result_ready_i) begin
            check("result expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check({e.name, " result"}, bus.result_o, e.res);
               check({e.name, " rd"}, bus.rd_o, e.rd);
               check({e.name, " latency"}, first_valid - e.acc_cyc + 1, e.lat);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e, c, acc[$];
      bit seen;
      rst_n              = 1'b1;
      flush_i            = 1'b0;
      bus.valid_i        = 1'b0;
      bus.op_i           = '0;
      bus.rs1_i          = '0;
      bus.rs2_i          = '0;
      bus.rd_i           = '0;
      bus.result_ready_i = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("reset ready_o", bus.ready_o, 1);
      check("reset busy_o", busy_o, 0);
      check("reset result_valid_o", bus.result_valid_o, 0);
      check("reset result_o", bus.result_o, 0);
      check("reset rd_o", bus.rd_o, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Requests that must be ignored: zero op, multi-hot op, flush in the same cycle
      drive(8'h00, 64'd1, 64'd1, 5'd1);
      @(posedge clk); #1;
      check("zero op ignored", busy_o, 0);
      drive(8'h03, 64'd1, 64'd1, 5'd1);
      @(posedge clk); #1;
      check("multi-hot op ignored", busy_o, 0);
      drive(OP_MUL, 64'd1, 64'd1, 5'd1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      check("request with flush ignored", busy_o, 0);
      flush_i     = 1'b0;
      bus.valid_i = 1'b0;
      @(posedge clk); #1;

      add("MUL 7*-3",        OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, LAT);
      add("MULHU ones*ones", OP_MULHU,  ONES,  ONES,   64'hFFFF_FFFF_FFFF_FFFE, LAT);
      add("MULH min*2",      OP_MULH,   MINV,  64'd2,  ONES, LAT);
      add("MULHSU -1*2",     OP_MULHSU, ONES,  64'd2,  ONES, LAT);
      add("MULHSU -1*2^63",  OP_MULHSU, ONES,  MINV,   ONES, LAT);
      add("MUL -3*-5",       OP_MUL,    64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, 64'd15, LAT);
      add("DIV -7/2",        OP_DIV,    M7,    64'd2,  64'hFFFF_FFFF_FFFF_FFFD, LAT);
      add("REM -7/2",        OP_REM,    M7,    64'd2,  ONES, LAT);
      add("DIV -7/-2",       OP_DIV,    M7,    64'hFFFF_FFFF_FFFF_FFFE, 64'd3, LAT);
      add("DIVU 100/7",      OP_DIVU,   64'd100, 64'd7, 64'd14, LAT);
      add("REMU 100/7",      OP_REMU,   64'd100, 64'd7, 64'd2, LAT);
      add("DIV 5/0",         OP_DIV,    64'd5, 64'd0,  ONES, LAT_SP);
      add("REM 5/0",         OP_REM,    64'd5, 64'd0,  64'd5, LAT_SP);
      add("REM -7/0",        OP_REM,    M7,    64'd0,  M7, LAT_SP);
      add("DIVU ones/0",     OP_DIVU,   ONES,  64'd0,  ONES, LAT_SP);
      add("DIV min/-1",      OP_DIV,    MINV,  ONES,   MINV, LAT_SP);
      add("REM min/-1",      OP_REM,    MINV,  ONES,   64'd0, LAT_SP);

      foreach (vq[i]) begin
         do_op(vq[i].name, vq[i].op, vq[i].a, vq[i].b, 5'(i + 1), vq[i].res, vq[i].lat, e);
         acc.push_back(e);
      end
      drain();
      check("back-to-back accept spacing", acc[1] - acc[0], XLEN + 2);

      // Consumer stall: result held in DONE, new request waits for the first IDLE cycle
      bus.result_ready_i = 1'b0;
      do_op("held MUL 3*5", OP_MUL, 64'd3, 64'd5, 5'd21, 64'd15, LAT, e);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = bus.result_valid_o;
      end
      check("held result appears", seen, 1);
      @(posedge clk); #1;
      drive(OP_DIVU, 64'd100, 64'd7, 5'd22);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold result_o stable", bus.result_o, 64'd15);
         check("hold rd_o stable", bus.rd_o, 21);
         check("hold ready_o low", bus.ready_o, 0);
         check("hold result_valid_o high", bus.result_valid_o, 1);
         @(posedge clk); #1;
      end
      bus.result_ready_i = 1'b1;
      c = cyc;
      wait_accept("post-hold DIVU", e);
      sb.push_back('{name: "post-hold DIVU 100/7", res: 64'd14, rd: 5'd22, lat: LAT, acc_cyc: e});
      check("post-hold accept delay", e - c, 2);
      drain();

      // Flush at CALC cycle 10: back to IDLE, no result ever appears
      drive(OP_MUL, 64'd9, 64'd9, 5'd23);
      wait_accept("flushed MUL", e);
      repeat (10) @(posedge clk);
      #1;
      flush_i = 1'b1;
      drive(OP_MUL, 64'd1, 64'd1, 5'd24);
      @(posedge clk); #1;
      flush_i     = 1'b0;
      bus.valid_i = 1'b0;
      check("flush busy_o", busy_o, 0);
      check("flush ready_o", bus.ready_o, 1);
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         seen = seen | bus.result_valid_o;
      end
      check("flush suppresses result", seen, 0);
      @(posedge clk); #1;
      do_op("after flush REMU 100/7", OP_REMU, 64'd100, 64'd7, 5'd25, 64'd2, LAT, e);
      drain();

      // Asynchronous reset at CALC cycle 20
      drive(OP_DIV, M7, 64'd2, 5'd26);
      wait_accept("reset-killed DIV", e);
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset result_valid_o", bus.result_valid_o, 0);
      check("async reset result_o", bus.result_o, 0);
      check("async reset rd_o", bus.rd_o, 0);
      check("async reset busy_o", busy_o, 0);
      check("async reset ready_o", bus.ready_o, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("after reset busy_o", busy_o, 0);
      do_op("after reset DIV -7/2", OP_DIV, M7, 64'd2, 5'd27, 64'hFFFF_FFFF_FFFF_FFFD, LAT, e);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
